// File: rtl/uart_boot_ctrl.sv
// UART boot command sequencer: parses ASCII hex into instruction words,
// writes them to instruction memory, gates the CPU run enable and returns
// one status byte per consumed command byte.
module uart_boot_ctrl #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned AW    = 4,
  parameter bit          ECHO  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_clr,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_wr,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_run,
  input  logic          cpu_halted,
  output logic [AW:0]   word_count
);

  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_DOT  = 8'h2E;
  localparam logic [7:0] CH_GT   = 8'h3E;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_Q    = 8'h3F;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_H    = 8'h48;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state_q, state_d;
  logic            tx_pend_q, tx_pend_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [2:0]      nib_q, nib_d;
  logic [27:0]     word_q, word_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            halted_q;
  logic            halt_req_q, halt_req_d;

  logic            rx_clr_d, tx_wr_d, imem_we_d, cpu_run_d;
  logic [7:0]      tx_data_d;
  logic [AW-1:0]   imem_addr_d;
  logic [31:0]     imem_wdata_d;
  logic [AW:0]     word_count_d;

  logic            hex_v;
  logic [3:0]      hex_n;
  logic            halt_evt;
  logic            accept;
  logic            resp_v;
  logic [7:0]      resp;

  // ASCII hex digit decode of the incoming byte
  always_comb begin
    hex_v = 1'b1;
    hex_n = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      hex_n = 4'(rx_data - 8'h30);
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      hex_n = 4'(rx_data - 8'h37);
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      hex_n = 4'(rx_data - 8'h57);
    end else begin
      hex_v = 1'b0;
    end
  end

  // Halt edge (or one deferred behind a pending response) outranks RX
  assign halt_evt = (state_q == RUN) && ((cpu_halted && !halted_q) || halt_req_q);
  assign accept   = rx_rdy && !rx_clr && !tx_pend_q && !halt_evt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshakes and command decode
  always_comb begin
    state_d      = state_q;
    tx_pend_d    = tx_pend_q;
    tx_byte_d    = tx_byte_q;
    nib_d        = nib_q;
    word_d       = word_q;
    addr_d       = addr_q;
    halt_req_d   = halt_req_q;
    rx_clr_d     = 1'b0;
    tx_wr_d      = 1'b0;
    tx_data_d    = tx_data;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    cpu_run_d    = cpu_run;
    word_count_d = word_count;
    resp_v       = 1'b0;
    resp         = 8'h00;

    if (tx_pend_q && !tx_busy) begin
      tx_wr_d   = 1'b1;
      tx_data_d = tx_byte_q;
      tx_pend_d = 1'b0;
    end

    if (halt_evt) begin
      if (!tx_pend_q) begin
        resp_v     = 1'b1;
        resp       = CH_H;
        halt_req_d = 1'b0;
      end else begin
        halt_req_d = 1'b1;
      end
    end else if (accept) begin
      rx_clr_d = 1'b1;
      if (rx_data != CH_CR && rx_data != CH_LF) begin
        resp_v = 1'b1;
        unique case (state_q)
          IDLE: begin
            if (rx_data == CH_L) begin
              state_d      = LOAD;
              addr_d       = '0;
              nib_d        = 3'd0;
              word_count_d = '0;
              resp         = CH_GT;
            end else if (rx_data == CH_R) begin
              state_d   = RUN;
              cpu_run_d = 1'b1;
              resp      = CH_K;
            end else begin
              resp = CH_Q;
            end
          end
          LOAD: begin
            if (hex_v) begin
              resp_v = ECHO;
              resp   = rx_data;
              if (nib_q == 3'd7) begin
                nib_d        = 3'd0;
                imem_we_d    = 1'b1;
                imem_addr_d  = addr_q;
                imem_wdata_d = {word_q, hex_n};
                if (word_count < CW'(WORDS)) word_count_d = word_count + CW'(1);
                if (addr_q == AW'(WORDS - 1)) begin
                  state_d = IDLE;
                  resp_v  = 1'b1;
                  resp    = CH_F;
                end else begin
                  addr_d = addr_q + AW'(1);
                end
              end else begin
                nib_d  = nib_q + 3'd1;
                word_d = {word_q[23:0], hex_n};
              end
            end else if (rx_data == CH_DOT) begin
              state_d = IDLE;
              resp    = (nib_q == 3'd0) ? CH_K : CH_BANG;
              nib_d   = 3'd0;
            end else begin
              nib_d = 3'd0;
              resp  = CH_Q;
            end
          end
          RUN: begin
            if (rx_data == CH_S) begin
              state_d   = IDLE;
              cpu_run_d = 1'b0;
              resp      = CH_K;
            end else begin
              resp = CH_Q;
            end
          end
          default: begin
            state_d = IDLE;
            resp    = CH_Q;
          end
        endcase
      end
    end

    if (resp_v) begin
      tx_pend_d = 1'b1;
      tx_byte_d = resp;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pend_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      nib_q      <= 3'd0;
      word_q     <= '0;
      addr_q     <= '0;
      halted_q   <= 1'b0;
      halt_req_q <= 1'b0;
      rx_clr     <= 1'b0;
      tx_wr      <= 1'b0;
      tx_data    <= 8'h00;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      word_count <= '0;
    end else begin
      tx_pend_q  <= tx_pend_d;
      tx_byte_q  <= tx_byte_d;
      nib_q      <= nib_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      halted_q   <= cpu_halted;
      halt_req_q <= halt_req_d;
      rx_clr     <= rx_clr_d;
      tx_wr      <= tx_wr_d;
      tx_data    <= tx_data_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_run    <= cpu_run_d;
      word_count <= word_count_d;
    end
  end

endmodule
